// File: rtl/effect_sample_sequencer.sv
// Feeds codec samples to one effect core over a my_turn/done handshake and collects one output per input.
// Optional dry/wet averaging of the effect result is enabled by defining EFFECT_SEQ_DRY_WET_MIX_EN.
module effect_sample_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic                         cs,
  input  logic                         effect_done,
  input  logic signed [DATA_WIDTH-1:0] effect_data,
  output logic signed [DATA_WIDTH-1:0] effect_data_in,
  output logic                         my_turn,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_out_valid,
  output logic                         busy,
  output logic [7:0]                   overrun_cnt,
  output logic [7:0]                   timeout_cnt
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] pending, dry, cand, effect_result;
  logic                         pending_valid, cand_valid, timeout_hit;
  logic [WW-1:0]                wdog;
  logic [GW-1:0]                gap;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef EFFECT_SEQ_DRY_WET_MIX_EN
  // One guard bit makes the sum exact; dropping the LSB is a floor halving.
  function automatic logic signed [DATA_WIDTH-1:0] mix(input logic signed [DATA_WIDTH-1:0] a,
                                                       input logic signed [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    return sum[DATA_WIDTH:1];
  endfunction
  assign effect_result = mix(dry, effect_data);
`else
  assign effect_result = effect_data;
`endif

  // A buffered sample always takes priority over a fresh strobe.
  assign cand_valid  = pending_valid | sample_valid;
  assign cand        = pending_valid ? pending : sample_in;
  assign timeout_hit = (wdog == WDOG_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cand_valid && cs)              state_nxt = WAIT_DONE;
      WAIT_DONE: if (effect_done || timeout_hit)    state_nxt = GAP;
      GAP:       if (gap == GAP_LAST)               state_nxt = IDLE;
      default:                                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      effect_data_in   <= '0;
      my_turn          <= 1'b0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      busy             <= 1'b0;
      overrun_cnt      <= '0;
      timeout_cnt      <= '0;
      pending          <= '0;
      pending_valid    <= 1'b0;
      dry              <= '0;
      wdog             <= '0;
      gap              <= '0;
    end else begin
      sample_out_valid <= 1'b0;
      busy             <= (state_nxt != IDLE);

      // Pending slot: drained in IDLE (refilled by a same-cycle strobe), filled otherwise.
      if (state == IDLE) begin
        if (pending_valid) begin
          pending_valid <= sample_valid;
          if (sample_valid) pending <= sample_in;
        end
      end else if (sample_valid) begin
        pending       <= sample_in;
        pending_valid <= 1'b1;
        if (pending_valid) overrun_cnt <= sat_inc(overrun_cnt);
      end

      case (state)
        IDLE: begin
          if (cand_valid) begin
            if (cs) begin
              effect_data_in <= cand;
              dry            <= cand;
              my_turn        <= 1'b1;
              wdog           <= '0;
            end else begin
              sample_out       <= cand;
              sample_out_valid <= 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          wdog <= wdog + 1'b1;
          if (effect_done) begin
            sample_out       <= effect_result;
            sample_out_valid <= 1'b1;
            my_turn          <= 1'b0;
            gap              <= '0;
          end else if (timeout_hit) begin
            sample_out       <= dry;
            sample_out_valid <= 1'b1;
            my_turn          <= 1'b0;
            gap              <= '0;
            timeout_cnt      <= sat_inc(timeout_cnt);
          end
        end
        GAP:     gap <= gap + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_effect_sample_sequencer.sv
// Self-checking bench for effect_sample_sequencer: directed scenarios plus a randomized run
// against a transaction-level model (issue time, handshake duration, pending slot).
module tb_effect_sample_sequencer;
  localparam int DW = 16;
  localparam int TO = 64;
  localparam int GP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          cs = 1'b0;
  logic          effect_done;
  logic [DW-1:0] effect_data;
  logic [DW-1:0] effect_data_in;
  logic          my_turn;
  logic [DW-1:0] sample_out;
  logic          sample_out_valid;
  logic          busy;
  logic [7:0]    overrun_cnt;
  logic [7:0]    timeout_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  effect_sample_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid), .cs(cs),
    .effect_done(effect_done), .effect_data(effect_data), .effect_data_in(effect_data_in),
    .my_turn(my_turn), .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .busy(busy), .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // Effect core stand-in: manual pulses for directed tests, automatic responder for random.
  logic          auto_fx = 1'b0, fx_done = 1'b0, man_done = 1'b0;
  logic [DW-1:0] fx_data = '0, man_data = '0;
  int            delays[$];
  int            fx_idx = 0, fx_cnt = 0;
  assign effect_done = auto_fx ? fx_done : man_done;
  assign effect_data = auto_fx ? fx_data : man_data;

  always @(negedge clk) begin
    if (auto_fx && my_turn) begin
      fx_cnt  = fx_cnt + 1;
      fx_done = (fx_cnt == delays[fx_idx]);
      fx_data = effect_data_in ^ 16'h5A5A;
    end else begin
      fx_done = 1'b0;
      if (fx_cnt > 0) begin
        fx_cnt = 0;
        fx_idx = fx_idx + 1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_fx(input logic [DW-1:0] d, input logic [DW-1:0] w);
    int s;
    s = int'($signed(d)) + int'($signed(w));
`ifdef EFFECT_SEQ_DRY_WET_MIX_EN
    s = s >>> 1;
`else
    s = int'($signed(w));
`endif
    return 16'(s);
  endfunction

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0; man_done = 1'b0; auto_fx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic strobe(input logic [DW-1:0] v, input logic c);
    sample_in = v; sample_valid = 1'b1; cs = c;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; sample_in = 16'hBEEF; sample_valid = 1'b1; cs = 1'b1;
    #1;
    n_cmp++; if ({my_turn, busy, sample_out_valid} !== 3'b000) begin n_bad++;
      $display("FAIL reset_ctrl: got %b required 000", {my_turn, busy, sample_out_valid}); end
    n_cmp++; if (sample_out !== 16'h0 || effect_data_in !== 16'h0) begin n_bad++;
      $display("FAIL reset_data: got %h/%h required 0000/0000", sample_out, effect_data_in); end
    n_cmp++; if (overrun_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin n_bad++;
      $display("FAIL reset_cnt: got %0d/%0d required 0/0", overrun_cnt, timeout_cnt); end
    sample_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    strobe(16'h1234, 1'b0);
    n_cmp++; if (sample_out !== 16'h1234 || sample_out_valid !== 1'b1) begin n_bad++;
      $display("FAIL bypass_out: got %h v=%b required 1234 v=1", sample_out, sample_out_valid); end
    n_cmp++; if (my_turn !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL bypass_turn: got turn=%b busy=%b required 0/0", my_turn, busy); end
    @(negedge clk);
    n_cmp++; if (sample_out !== 16'h1234 || sample_out_valid !== 1'b0) begin n_bad++;
      $display("FAIL bypass_hold: got %h v=%b required 1234 v=0", sample_out, sample_out_valid); end
  endtask

  task automatic test_effect(input logic [DW-1:0] dry, input logic [DW-1:0] wet);
    logic held = 1'b1;
    logic [DW-1:0] e;
    e = exp_fx(dry, wet);
    do_reset();
    @(negedge clk);
    strobe(dry, 1'b1);
    n_cmp++; if (my_turn !== 1'b1 || effect_data_in !== dry || busy !== 1'b1) begin n_bad++;
      $display("FAIL effect_issue: got turn=%b data=%h busy=%b required 1/%h/1", my_turn, effect_data_in, busy, dry); end
    cs = 1'b0;
    repeat (19) begin
      @(negedge clk);
      if (my_turn !== 1'b1 || effect_data_in !== dry || sample_out_valid !== 1'b0) held = 1'b0;
    end
    man_data = wet; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    n_cmp++; if (held !== 1'b1) begin n_bad++;
      $display("FAIL effect_wait: got held=%b required 1", held); end
    n_cmp++; if (sample_out !== e || sample_out_valid !== 1'b1 || my_turn !== 1'b0) begin n_bad++;
      $display("FAIL effect_out: got %h v=%b turn=%b required %h v=1 turn=0", sample_out, sample_out_valid, my_turn, e); end
    for (int i = 0; i < GP; i++) begin
      @(negedge clk);
      n_cmp++; if (my_turn !== 1'b0 || busy !== (i < GP - 1)) begin n_bad++;
        $display("FAIL effect_gap%0d: got turn=%b busy=%b required 0/%b", i, my_turn, busy, i < GP - 1); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    @(negedge clk);
    strobe(16'h1111, 1'b1);
    @(negedge clk);
    strobe(16'h2222, 1'b1);
    strobe(16'h3333, 1'b1);
    strobe(16'h4444, 1'b1);
    n_cmp++; if (overrun_cnt !== 8'd2) begin n_bad++;
      $display("FAIL overrun_cnt: got %0d required 2", overrun_cnt); end
    man_data = 16'h0001; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (GP) @(negedge clk);
    n_cmp++; if (my_turn !== 1'b0) begin n_bad++;
      $display("FAIL overrun_gap: got turn=%b required 0", my_turn); end
    @(negedge clk);
    n_cmp++; if (my_turn !== 1'b1 || effect_data_in !== 16'h4444) begin n_bad++;
      $display("FAIL overrun_next: got turn=%b data=%h required 1/4444", my_turn, effect_data_in); end
  endtask

  task automatic test_timeout();
    logic quiet = 1'b1;
    do_reset();
    @(negedge clk);
    strobe(16'hFFF0, 1'b1);
    repeat (TO - 1) begin
      @(negedge clk);
      if (sample_out_valid !== 1'b0 || my_turn !== 1'b1) quiet = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (quiet !== 1'b1) begin n_bad++;
      $display("FAIL timeout_early: got quiet=%b required 1", quiet); end
    n_cmp++; if (sample_out !== 16'hFFF0 || sample_out_valid !== 1'b1 || my_turn !== 1'b0) begin n_bad++;
      $display("FAIL timeout_out: got %h v=%b turn=%b required fff0 v=1 turn=0", sample_out, sample_out_valid, my_turn); end
    n_cmp++; if (timeout_cnt !== 8'd1) begin n_bad++;
      $display("FAIL timeout_cnt: got %0d required 1", timeout_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    strobe(16'h0777, 1'b1);
    strobe(16'h0888, 1'b1);
    strobe(16'h0999, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (my_turn !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL midrst_ctrl: got turn=%b busy=%b required 0/0", my_turn, busy); end
    n_cmp++; if (overrun_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin n_bad++;
      $display("FAIL midrst_cnt: got %0d/%0d required 0/0", overrun_cnt, timeout_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    strobe(16'h0ABC, 1'b0);
    n_cmp++; if (sample_out !== 16'h0ABC || sample_out_valid !== 1'b1 || my_turn !== 1'b0) begin n_bad++;
      $display("FAIL midrst_after: got %h v=%b turn=%b required 0abc v=1 turn=0", sample_out, sample_out_valid, my_turn); end
  endtask

  task automatic test_random();
    localparam int NCYC = 4000;
    logic [DW-1:0] expq[$];
    logic [DW-1:0] pend = '0, cand = '0, si, e;
    logic pv = 1'b0, have, sv, c;
    int free_at = 0, k = 0, ovr = 0, tmo = 0, d, nout = 0;
    do_reset();
    delays.delete();
    for (int i = 0; i < 1500; i++) delays.push_back($urandom_range(TO + 8, 1));
    fx_idx = 0; fx_cnt = 0; auto_fx = 1'b1;
    for (int t = 0; t < NCYC + 300; t++) begin
      @(negedge clk);
      if (sample_out_valid === 1'b1) begin
        nout++;
        n_cmp++;
        if (expq.size() == 0) begin n_bad++;
          $display("FAIL rand_extra: got %h at cycle %0d required no output", sample_out, t); end
        else begin
          e = expq.pop_front();
          if (sample_out !== e) begin n_bad++;
            $display("FAIL rand_out%0d: got %h required %h", nout, sample_out, e); end
        end
      end
      sv = (t < NCYC) && ($urandom_range(3) == 0);
      si = 16'($urandom);
      c  = ($urandom_range(3) != 0);
      sample_valid = sv; sample_in = si; cs = c;
      // Model: DUT accepts work only from free_at on; otherwise strobes land in the one-deep slot.
      if (t >= free_at) begin
        have = 1'b0;
        if (pv) begin cand = pend; have = 1'b1; if (sv) pend = si; else pv = 1'b0; end
        else if (sv) begin cand = si; have = 1'b1; end
        if (have && c) begin
          d = delays[k]; k++;
          if (d <= TO) expq.push_back(exp_fx(cand, cand ^ 16'h5A5A));
          else begin expq.push_back(cand); tmo++; end
          free_at = t + ((d <= TO) ? d : TO) + GP + 1;
        end else if (have) expq.push_back(cand);
      end else if (sv) begin
        if (pv) ovr++;
        pend = si; pv = 1'b1;
      end
    end
    sample_valid = 1'b0;
    @(negedge clk);
    auto_fx = 1'b0;
    n_cmp++; if (expq.size() != 0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL rand_drain: got %0d missing busy=%b required 0/0", expq.size(), busy); end
    n_cmp++; if (overrun_cnt !== sat8(ovr)) begin n_bad++;
      $display("FAIL rand_overrun: got %0d required %0d", overrun_cnt, sat8(ovr)); end
    n_cmp++; if (timeout_cnt !== sat8(tmo)) begin n_bad++;
      $display("FAIL rand_timeout: got %0d required %0d", timeout_cnt, sat8(tmo)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_bypass();
    test_effect(16'h0100, 16'h0040);
    test_effect(16'h8000, 16'h8000);
    test_effect(16'h7FFF, 16'h7FFF);
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
